spi_master_ctrl: RTL

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_ctrl
// Description : Command-driven SPI master. Serialises a 10-bit command word
//               MSB first on mosi. For read-data commands it waits a
//               configurable turnaround and then clocks in one byte from
//               miso, which it presents on rd_data with a one-cycle rd_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_ctrl #(
    parameter int TURNAROUND = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [9:0] cmd_data,
    output logic       cmd_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       ss_n,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SHIFT = 3'd2,
        WAIT  = 3'd3,
        RECV  = 3'd4,
        END   = 3'd5
    } state_t;

    // Last value of the cycle counter while in WAIT (unused when TURNAROUND==0)
    localparam logic [3:0] C_WAIT_LAST = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;
    localparam logic [1:0] C_OP_RDDATA = 2'b11;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_cnt;
    logic [9:0] r_sr;
    logic [1:0] r_op;
    logic [7:0] r_rx;
    logic [7:0] r_rd_data;
    logic       r_rd_valid;
    logic       w_accept;

    assign w_accept = cmd_valid && (r_state == IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and frame outputs, all decoded from the current state
    always_comb begin
        w_state_next = r_state;
        ss_n         = 1'b0;
        mosi         = 1'b0;
        cmd_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                ss_n      = 1'b1;
                cmd_ready = 1'b1;
                if (w_accept) begin
                    w_state_next = START;
                end
            end
            START: begin
                w_state_next = SHIFT;
            end
            SHIFT: begin
                mosi = r_sr[9];
                if (r_cnt == 4'd9) begin
                    if (r_op != C_OP_RDDATA) begin
                        w_state_next = END;
                    end else if (TURNAROUND == 0) begin
                        w_state_next = RECV;
                    end else begin
                        w_state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == C_WAIT_LAST) begin
                    w_state_next = RECV;
                end
            end
            RECV: begin
                if (r_cnt == 4'd7) begin
                    w_state_next = END;
                end
            end
            END: begin
                ss_n         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                ss_n         = 1'b1;
                w_state_next = IDLE;
            end
        endcase
    end

    assign busy = ~cmd_ready;

    // Per-state cycle counter: restarts on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (w_state_next != r_state) begin
            r_cnt <= 4'd0;
        end else if ((r_state == SHIFT) || (r_state == WAIT) || (r_state == RECV)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // Command latch and MOSI shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= 10'd0;
            r_op <= 2'b00;
        end else if (w_accept) begin
            r_sr <= cmd_data;
            r_op <= cmd_data[9:8];
        end else if (r_state == SHIFT) begin
            r_sr <= {r_sr[8:0], 1'b0};
        end
    end

    // MISO capture; rd_data is only written on the final RECV edge, so an
    // aborted read never leaves a partial byte behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx       <= 8'd0;
            r_rd_data  <= 8'd0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            if (r_state == RECV) begin
                r_rx <= {r_rx[6:0], miso};
                if (r_cnt == 4'd7) begin
                    r_rd_data  <= {r_rx[6:0], miso};
                    r_rd_valid <= 1'b1;
                end
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

endmodule
`default_nettype wire
